// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the exception controller.
//   exc_state_t   controller state (RUN, HANDLER, LOCK); encoding is visible
//                 to software through the SYS_STATE system register.
//   ES_*          decoder EStatus encodings.
//   SYS_*         MRS system-register selects.
package exc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        HANDLER = 2'b01,
        LOCK    = 2'b10
    } exc_state_t;

    localparam logic [3:0] ES_NONE    = 4'b0000;
    localparam logic [3:0] ES_IRQ     = 4'b0001;
    localparam logic [3:0] ES_INVALID = 4'b0010;

    localparam logic [1:0] SYS_ELR   = 2'b00;
    localparam logic [1:0] SYS_ESR   = 2'b01;
    localparam logic [1:0] SYS_STATE = 2'b10;
    localparam logic [1:0] SYS_ZERO  = 2'b11;

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// irq_sync: two-flop synchronizer for the external interrupt level.
//   clk    clock
//   reset  asynchronous active-high reset, clears both flops
//   d      asynchronous input level
//   q      synchronized level, two clk edges behind d
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception controller sitting behind the main decoder.
// Takes exceptions reported on EStatus, latches the return address (ERR_PC)
// and syndrome (ESR), masks the external interrupt while a handler runs, and
// locks up on a fault inside a handler (double fault) until reset.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   PC           address of the instruction executing this cycle
//   EStatus      decoder status (0 none, 1 IRQ, 2 invalid, others invalid)
//   ERet         ERET executing this cycle
//   IrqReq       raw interrupt level from the device
//   ExtIRQ       masked interrupt request back to the decoder
//   IrqAck       one-cycle acknowledge to the device
//   Exc          take exception this cycle (PC mux selects ExcPC)
//   ExcPC        handler address, constant VECTOR
//   ERR_PC, ESR  exception link register and syndrome
//   SysSel       MRS select: 00 ERR_PC, 01 ESR, 10 state, 11 zero
//   SysData      combinational read of the selected register
//   Halted       double-fault lock indicator
//
// Build option: define EXC_IRQ_SYNC_EN to pass IrqReq through a two-flop
// synchronizer (two cycles of latency) instead of using it directly.
//
// Interrupt handshake: the device holds IrqReq high until it sees IrqAck.
// IrqAck pulses for exactly one cycle, the cycle after the controller takes
// the IRQ. A level still high after that pulse is masked in HANDLER and is
// seen again on the first RUN cycle after ERET.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int           N      = 64,
    parameter logic [N-1:0] VECTOR = 'h0000_0000_0000_00D8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PC,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         IrqReq,
    output logic         ExtIRQ,
    output logic         IrqAck,
    output logic         Exc,
    output logic [N-1:0] ExcPC,
    output logic [N-1:0] ERR_PC,
    output logic [3:0]   ESR,
    input  logic [1:0]   SysSel,
    output logic [N-1:0] SysData,
    output logic         Halted
);

    exc_state_t state;
    logic       irq_eff;

`ifdef EXC_IRQ_SYNC_EN
    irq_sync u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (IrqReq),
        .q     (irq_eff)
    );
`else
    assign irq_eff = IrqReq;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            ERR_PC <= '0;
            ESR    <= '0;
            IrqAck <= 1'b0;
        end else begin
            IrqAck <= 1'b0;
            case (state)
                RUN: begin
                    // Any nonzero status wins over ERET.
                    if (EStatus != ES_NONE) begin
                        ESR   <= EStatus;
                        state <= HANDLER;
                        if (EStatus == ES_IRQ) begin
                            // Interrupted instruction commits; resume after it.
                            ERR_PC <= PC + N'(4);
                            IrqAck <= 1'b1;
                        end else begin
                            // Faulting instruction is retried after return.
                            ERR_PC <= PC;
                        end
                    end
                end
                HANDLER: begin
                    // Fault inside the handler keeps the original ERR_PC.
                    if (EStatus != ES_NONE) begin
                        ESR   <= EStatus;
                        state <= LOCK;
                    end else if (ERet) begin
                        state <= RUN;
                    end
                end
                LOCK: begin
                    state <= LOCK;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Reset forces the combinational outputs low as well, so the core sees
    // a quiet controller for the whole reset pulse.
    always_comb begin
        Exc = 1'b0;
        case (state)
            RUN, HANDLER: Exc = (EStatus != ES_NONE);
            LOCK:         Exc = 1'b1;
            default:      Exc = 1'b0;
        endcase
        if (reset) Exc = 1'b0;
    end

    assign ExtIRQ = irq_eff & (state == RUN) & ~reset;
    assign Halted = (state == LOCK);
    assign ExcPC  = VECTOR;

    always_comb begin
        SysData = '0;
        case (SysSel)
            SYS_ELR:   SysData = ERR_PC;
            SYS_ESR:   SysData = {{(N-4){1'b0}}, ESR};
            SYS_STATE: SysData = {{(N-2){1'b0}}, state};
            default:   SysData = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed bench for exc_ctrl with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked in the same cycle before the next edge, registered outputs after
// the edge that updates them.
module tb_exc_ctrl;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] pc;
    logic [3:0]   estatus;
    logic         eret;
    logic         irq_req;
    logic         ext_irq;
    logic         irq_ack;
    logic         exc;
    logic [N-1:0] exc_pc;
    logic [N-1:0] err_pc;
    logic [3:0]   esr;
    logic [1:0]   sys_sel;
    logic [N-1:0] sys_data;
    logic         halted;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    exc_ctrl #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .PC      (pc),
        .EStatus (estatus),
        .ERet    (eret),
        .IrqReq  (irq_req),
        .ExtIRQ  (ext_irq),
        .IrqAck  (irq_ack),
        .Exc     (exc),
        .ExcPC   (exc_pc),
        .ERR_PC  (err_pc),
        .ESR     (esr),
        .SysSel  (sys_sel),
        .SysData (sys_data),
        .Halted  (halted)
    );

    task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] p, input logic [3:0] es, input logic er);
        pc      = p;
        estatus = es;
        eret    = er;
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp);
        logic [1:0] saved;
        saved   = sys_sel;
        sys_sel = 2'b10;
        #1;
        check(tag, sys_data, {62'd0, exp});
        sys_sel = saved;
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        pc      = '0;
        estatus = 4'b0000;
        eret    = 1'b0;
        irq_req = 1'b0;
        sys_sel = 2'b10;

        // reset then idle
        step();
        check("rst_exc", {63'd0, exc}, 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("idle_exc",     {63'd0, exc},     64'd0);
        check("idle_extirq",  {63'd0, ext_irq}, 64'd0);
        check("idle_ack",     {63'd0, irq_ack}, 64'd0);
        check("idle_halted",  {63'd0, halted},  64'd0);
        check("idle_errpc",   err_pc,           64'd0);
        check("idle_esr",     {60'd0, esr},     64'd0);
        check("idle_state",   sys_data,         64'd0);
        check("excpc",        exc_pc,           64'h0000_0000_0000_00D8);
        step();

        // invalid opcode in RUN
        drive(64'h40, 4'b0010, 1'b0);
        check("inv_exc_same_cycle", {63'd0, exc}, 64'd1);
        step();
        irq_req = 1'b1;
        drive(64'h44, 4'b0000, 1'b0);
        check("inv_errpc",   err_pc,           64'h40);
        check("inv_esr",     {60'd0, esr},     64'd2);
        check("inv_extirq_masked", {63'd0, ext_irq}, 64'd0);
        check("inv_no_ack",  {63'd0, irq_ack}, 64'd0);
        check("inv_exc_low", {63'd0, exc},     64'd0);
        check_state("inv_state", 2'b01);

        // ERET back to RUN; held IrqReq shows up again
        drive(64'h48, 4'b0000, 1'b1);
        check("handler_eret_exc", {63'd0, exc}, 64'd0);
        step();
        drive(64'h40, 4'b0000, 1'b0);
        check_state("eret_state", 2'b00);
        check("eret_extirq", {63'd0, ext_irq}, 64'd1);

        // IRQ handshake
        drive(64'h100, 4'b0001, 1'b0);
        check("irq_exc", {63'd0, exc}, 64'd1);
        check("irq_ack_pre", {63'd0, irq_ack}, 64'd0);
        step();
        drive(64'hD8, 4'b0000, 1'b0);
        check("irq_errpc", err_pc, 64'h104);
        check("irq_esr", {60'd0, esr}, 64'd1);
        check("irq_ack_pulse", {63'd0, irq_ack}, 64'd1);
        check("irq_masked", {63'd0, ext_irq}, 64'd0);
        step();
        check("irq_ack_done", {63'd0, irq_ack}, 64'd0);
        check("irq_still_masked", {63'd0, ext_irq}, 64'd0);
        drive(64'hDC, 4'b0000, 1'b1);
        step();
        drive(64'h104, 4'b0000, 1'b0);
        check_state("irq_ret_state", 2'b00);
        check("irq_ret_extirq", {63'd0, ext_irq}, 64'd1);
        check("irq_ret_errpc", err_pc, 64'h104);
        check("irq_ret_ack", {63'd0, irq_ack}, 64'd0);

        // IRQ return address wraps modulo 2^N
        drive(64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, 1'b0);
        step();
        check("wrap_errpc", err_pc, 64'h2);
        drive(64'hD8, 4'b0000, 1'b1);
        step();
        irq_req = 1'b0;

        // stray ERET in RUN: nothing moves
        drive(64'h200, 4'b0000, 1'b1);
        check("stray_exc", {63'd0, exc}, 64'd0);
        step();
        drive(64'h204, 4'b0000, 1'b0);
        check_state("stray_state", 2'b00);
        check("stray_errpc", err_pc, 64'h2);
        check("stray_esr", {60'd0, esr}, 64'd1);

        // reserved status is an invalid opcode
        drive(64'h300, 4'b1000, 1'b0);
        check("rsv_exc", {63'd0, exc}, 64'd1);
        step();
        drive(64'hD8, 4'b0000, 1'b0);
        check("rsv_errpc", err_pc, 64'h300);
        check("rsv_esr", {60'd0, esr}, 64'd8);
        check_state("rsv_state", 2'b01);

        // fault in handler with simultaneous ERET: fault wins, LOCK
        drive(64'hDC, 4'b0010, 1'b1);
        check("dbl_exc", {63'd0, exc}, 64'd1);
        step();
        irq_req = 1'b1;
        drive(64'hD8, 4'b0000, 1'b1);
        check_state("dbl_state", 2'b10);
        check("dbl_halted", {63'd0, halted}, 64'd1);
        check("dbl_exc_lock", {63'd0, exc}, 64'd1);
        check("dbl_errpc", err_pc, 64'h300);
        check("dbl_esr", {60'd0, esr}, 64'd2);
        step();
        drive(64'hD8, 4'b0001, 1'b1);
        step();
        check_state("lock_sticky", 2'b10);
        check("lock_extirq", {63'd0, ext_irq}, 64'd0);
        check("lock_esr", {60'd0, esr}, 64'd2);
        sys_sel = 2'b00;
        #1;
        check("lock_sys_elr", sys_data, 64'h300);
        sys_sel = 2'b01;
        #1;
        check("lock_sys_esr", sys_data, 64'd2);
        sys_sel = 2'b11;
        #1;
        check("lock_sys_zero", sys_data, 64'd0);
        sys_sel = 2'b10;

        // async reset in the middle of a cycle
        #1;
        reset = 1'b1;
        #1;
        check("arst_exc", {63'd0, exc}, 64'd0);
        check("arst_halted", {63'd0, halted}, 64'd0);
        check("arst_errpc", err_pc, 64'd0);
        check("arst_esr", {60'd0, esr}, 64'd0);
        check("arst_extirq", {63'd0, ext_irq}, 64'd0);
        check("arst_ack", {63'd0, irq_ack}, 64'd0);
        check("arst_state", sys_data, 64'd0);
        drive(64'h0, 4'b0000, 1'b0);
        step();
        reset = 1'b0;
        #1;

`ifdef EXC_IRQ_SYNC_EN
        // synchronizer latency: IrqReq already high at release
        check("sync_rel0", {63'd0, ext_irq}, 64'd0);
        step();
        check("sync_rel1", {63'd0, ext_irq}, 64'd0);
        step();
        check("sync_rel2", {63'd0, ext_irq}, 64'd1);
        irq_req = 1'b0;
        step();
        step();
        check("sync_low", {63'd0, ext_irq}, 64'd0);
        // rise at cycle 0, reset at cycle 1
        irq_req = 1'b1;
        step();
        reset = 1'b1;
        #1;
        check("sync_rst_clr", {63'd0, ext_irq}, 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("sync_after_rst0", {63'd0, ext_irq}, 64'd0);
        step();
        check("sync_after_rst1", {63'd0, ext_irq}, 64'd0);
        step();
        check("sync_after_rst2", {63'd0, ext_irq}, 64'd1);
`else
        check("post_rst_extirq", {63'd0, ext_irq}, 64'd1);
        irq_req = 1'b0;
        #1;
        check("post_rst_extirq_low", {63'd0, ext_irq}, 64'd0);
`endif

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception controller directly downstream of the main decoder.
- Consumes the decoder's EStatus and ERet outputs plus the current PC.
- Decides when an exception is taken, latches the return address (ERR_PC) and the syndrome (ESR), and masks and handshakes the external interrupt.
- Supplies the masked ExtIRQ back to the decoder and system-register data to the MRS path.

Parameters:
- N, 64, datapath/PC width.
- VECTOR, 64'h0000_0000_0000_00D8, exception handler address driven on ExcPC.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- PC  in  N  address of the instruction executing this cycle
- EStatus  in  4  decoder status: 0000 none, 0001 external IRQ, 0010 invalid opcode; other values reserved, treated as invalid
- ERet  in  1  decoder: ERET executing this cycle
- IrqReq  in  1  raw external interrupt level; held by the device until acknowledged
- ExtIRQ  out  1  masked interrupt request to the decoder
- IrqAck  out  1  one-cycle acknowledge to the device
- Exc  out  1  take exception this cycle; PC mux selects ExcPC
- ExcPC  out  N  always VECTOR
- ERR_PC  out  N  exception link register; ERET target
- ESR  out  4  latched EStatus of the last taken exception
- SysSel  in  2  MRS register select: 00 ERR_PC, 01 ESR (zero-extended), 10 {N-2 zeros, state[1:0]}, 11 zero
- SysData  out  N  combinational read of the selected system register
- Halted  out  1  double-fault lock indicator

Behaviour:
- States: RUN (00), HANDLER (01), LOCK (10).
- Reset (async, any state, including mid-handler): state=RUN, ERR_PC=0, ESR=0, IrqAck=0, Exc=0, Halted=0, irq latch cleared.
- ExtIRQ = IrqReq_eff & (state==RUN), combinational. IrqReq_eff is the raw IrqReq, or the synchronized IrqReq with the optional feature.
- RUN:
  - EStatus!=0 → Exc=1 combinationally in the same cycle.
  - At the next clk edge: ESR<=EStatus, state<=HANDLER.
  - ERR_PC<=PC for an invalid opcode; the faulting instruction does not commit.
  - ERR_PC<=PC+4 for IRQ (EStatus==0001); the current instruction commits. Addition modulo 2^N.
  - IrqAck registered: high for exactly the one cycle after the IRQ edge.
- RUN with ERet=1 and EStatus==0: no state change and no register update.
- HANDLER:
  - ExtIRQ is masked, so the decoder cannot report 0001.
  - ERet=1 → state<=RUN at the edge; the datapath uses ERR_PC as the next PC. Exc=0.
  - EStatus!=0 (invalid opcode inside the handler) → Exc=1, ESR<=EStatus, ERR_PC unchanged, state<=LOCK.
- LOCK:
  - Halted=1 and Exc=1 every cycle, so the core spins at VECTOR.
  - All inputs are ignored; only reset exits.
- Simultaneous EStatus!=0 and ERet: the exception has priority and ERet is ignored.
- IrqReq still high after the acknowledge: it is masked in HANDLER. On return to RUN it triggers again only if still asserted, in the first RUN cycle.
- SysData reflects register values as of the current cycle (pre-edge).

Optional Feature:
- Macro: EXC_IRQ_SYNC_EN.
- Defined: IrqReq passes through a two-flop synchronizer, both flops reset to 0. ExtIRQ rises 2 cycles after IrqReq. The synchronizer clears on reset.
- Undefined: IrqReq is used directly, with zero latency.

Decomposition:
- Package exc_pkg:
  - exc_state_t enum (RUN, HANDLER, LOCK)
  - EStatus constants ES_NONE=4'b0000, ES_IRQ=4'b0001, ES_INVALID=4'b0010
  - SysSel constants SYS_ELR, SYS_ESR, SYS_STATE
- One sub-module, irq_sync: two-flop synchronizer, instantiated only under EXC_IRQ_SYNC_EN.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release, EStatus=0 → all outputs 0, state 00, SysSel=10 gives SysData=0.
- Invalid opcode: PC=64'h40, EStatus=0010 → Exc=1 same cycle; next cycle ERR_PC=64'h40, ESR=0010, ExtIRQ=0 even with IrqReq=1.
- IRQ handshake: IrqReq=1 → ExtIRQ=1. Drive EStatus=0001, PC=64'h100 → ERR_PC=64'h104, IrqAck high exactly one cycle. Hold IrqReq=1; ExtIRQ stays 0 in HANDLER. ERet=1 → RUN next edge, ExtIRQ=1 again.
- Double fault: in HANDLER, EStatus=0010 → LOCK, Halted=1, Exc=1. ERet=1 has no effect. Async reset mid-cycle → all outputs 0 immediately.
- Priority and stray ERet: in RUN, ERet=1 with EStatus=0 → stays RUN, ERR_PC unchanged. In HANDLER, ERet=1 with EStatus=0010 → LOCK.
- With EXC_IRQ_SYNC_EN: IrqReq rises at cycle 0 → ExtIRQ=1 at cycle 2. Reset at cycle 1 → ExtIRQ stays 0 until 2 cycles after reset release.
